// File: rtl/Opcodes_pkg.sv
// RV32I opcode and funct3 encodings used by the branch unit.
// Shared with the decoder and the rest of the Vermicel core.
package Opcodes_pkg;

   typedef logic [6:0] opcode_t;
   typedef logic [2:0] funct3_t;

   localparam opcode_t OPCODE_BRANCH = 7'b1100011;
   localparam opcode_t OPCODE_OP_IMM = 7'b0010011;

   localparam funct3_t FUNCT3_BEQ  = 3'b000;
   localparam funct3_t FUNCT3_BNE  = 3'b001;
   localparam funct3_t FUNCT3_BLT  = 3'b100;
   localparam funct3_t FUNCT3_BGE  = 3'b101;
   localparam funct3_t FUNCT3_BLTU = 3'b110;
   localparam funct3_t FUNCT3_BGEU = 3'b111;

   // addi x0, x0, 0
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/Types_pkg.sv
// Core-wide data types: machine word and decoded instruction.
// Field layout mirrors the raw RV32 instruction word.
package Types_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      logic [6:0]            funct7;
      logic [4:0]            rs2;
      logic [4:0]            rs1;
      Opcodes_pkg::funct3_t  funct3;
      logic [4:0]            rd;
      Opcodes_pkg::opcode_t  opcode;
   } instruction_t;

endpackage

// File: rtl/comparator.sv
// Branch-condition evaluator: combinational taken flag plus
// a registered copy and a taken-branch event counter.
module comparator
   import Opcodes_pkg::*;
   import Types_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  instruction_t instr,
   input  word_t        a,
   input  word_t        b,
   output logic         taken,
   output logic         taken_q,
   output logic [31:0]  branch_count
);

   logic        eq;
   logic        ltu;
   logic        lt;
   logic [31:0] count_q;
   logic [31:0] count_d;
   logic        unused_instr;

   // Only opcode and funct3 matter here.
   assign unused_instr = ^{instr.funct7, instr.rs2,
                           instr.rs1, instr.rd};

   // Everything is built from one equality and one
   // unsigned less-than; signs only break ties on bit 31.
   assign eq  = (a == b);
   assign ltu = (a < b);
   assign lt  = (a[31] != b[31]) ? a[31] : ltu;

   // Select the condition by funct3; opcode is ignored.
   always_comb begin
      taken = 1'b0;
      case (instr.funct3)
         FUNCT3_BEQ:  taken = eq;
         FUNCT3_BNE:  taken = !eq;
         FUNCT3_BLT:  taken = lt;
         FUNCT3_BGE:  taken = !lt;
         FUNCT3_BLTU: taken = ltu;
         FUNCT3_BGEU: taken = !ltu;
         default:     taken = 1'b0;
      endcase
   end

   // Count only real branches that resolve taken; wraps.
   always_comb begin
      count_d = count_q;
      if (instr.opcode == OPCODE_BRANCH && taken) begin
         count_d = count_q + 32'd1;
      end
   end

   // Registered decision and counter, async clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         taken_q <= 1'b0;
         count_q <= '0;
      end else begin
         taken_q <= taken;
         count_q <= count_d;
      end
   end

   assign branch_count = count_q;

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for the branch comparator.
// Expected values go through a scoreboard queue.
module tb_comparator;
   import Opcodes_pkg::*;
   import Types_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n;
   instruction_t instr;
   word_t        a;
   word_t        b;
   logic         taken;
   logic         taken_q;
   logic [31:0]  branch_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] mdl_cnt;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      funct3_t f3;
      int      x;
      int      y;
      bit      t;
   } vec_t;

   vec_t vecs[18] = '{
      '{FUNCT3_BEQ,   10,  10, 1'b1},
      '{FUNCT3_BEQ,   10,  20, 1'b0},
      '{FUNCT3_BEQ,  -10, -10, 1'b1},
      '{FUNCT3_BNE,  -10, -20, 1'b1},
      '{FUNCT3_BNE,   10,  10, 1'b0},
      '{FUNCT3_BLT,  -10,  20, 1'b1},
      '{FUNCT3_BLT,   10, -20, 1'b0},
      '{FUNCT3_BLT,  -10, -10, 1'b0},
      '{FUNCT3_BLT,  -10, -20, 1'b0},
      '{FUNCT3_BGE,   10, -20, 1'b1},
      '{FUNCT3_BGE,  -10,  20, 1'b0},
      '{FUNCT3_BGE,  -10, -10, 1'b1},
      '{FUNCT3_BLTU,  10, -20, 1'b1},
      '{FUNCT3_BLTU, -10,  20, 1'b0},
      '{FUNCT3_BLTU,  10,  10, 1'b0},
      '{FUNCT3_BGEU, -10,  20, 1'b1},
      '{FUNCT3_BGEU,  10, -20, 1'b0},
      '{FUNCT3_BGEU, -10, -20, 1'b1}
   };

   comparator dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .instr        (instr),
      .a            (a),
      .b            (b),
      .taken        (taken),
      .taken_q      (taken_q),
      .branch_count (branch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag,
                       input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] got);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check(e.tag, got, e.exp);
   endtask

   function automatic bit ref_taken(input funct3_t f3,
                                    input word_t x,
                                    input word_t y);
      case (f3)
         3'b000:  return x == y;
         3'b001:  return x != y;
         3'b100:  return $signed(x) <  $signed(y);
         3'b101:  return $signed(x) >= $signed(y);
         3'b110:  return x <  y;
         3'b111:  return x >= y;
         default: return 1'b0;
      endcase
   endfunction

   task automatic comb_vec(input funct3_t f3,
                           input word_t x,
                           input word_t y,
                           input bit t,
                           input string tag);
      @(negedge clk);
      instr.funct3 = f3;
      a = x;
      b = y;
      push(tag, 32'(t));
      #1;
      pop_check(32'(taken));
   endtask

   task automatic step(input opcode_t op,
                       input funct3_t f3,
                       input word_t x,
                       input word_t y,
                       input bit rel);
      bit t;
      @(negedge clk);
      if (rel) reset_n = 1'b1;
      instr.opcode = op;
      instr.funct3 = f3;
      a = x;
      b = y;
      t = ref_taken(f3, x, y);
      if (op == OPCODE_BRANCH && t) mdl_cnt++;
      push("taken_q", 32'(t));
      push("count", mdl_cnt);
      @(posedge clk);
      #1;
      pop_check(32'(taken_q));
      pop_check(branch_count);
   endtask

   initial begin
      reset_n = 1'b0;
      instr   = INSTR_NOP;
      instr.opcode = OPCODE_BRANCH;
      a = '0;
      b = '0;
      mdl_cnt = '0;

      // decision must be valid even while reset is held
      foreach (vecs[i]) begin
         comb_vec(vecs[i].f3, word_t'(vecs[i].x),
                  word_t'(vecs[i].y), vecs[i].t,
                  $sformatf("cmp%0d", i));
      end

      @(negedge clk);
      instr = INSTR_NOP;
      a = 32'd10;
      b = 32'd10;
      push("nop_beq", 32'd1);
      #1;
      pop_check(32'(taken));

      comb_vec(3'b010, $urandom, $urandom, 1'b0, "f3_010");
      comb_vec(3'b011, 32'd5, 32'd5, 1'b0, "f3_011");

      check("rst_taken_q", 32'(taken_q), 32'd0);
      check("rst_count", branch_count, 32'd0);

      // release and count three taken branches
      step(OPCODE_BRANCH, FUNCT3_BEQ, 32'd5, 32'd5, 1'b1);
      step(OPCODE_BRANCH, FUNCT3_BEQ, 32'd5, 32'd5, 1'b0);
      step(OPCODE_BRANCH, FUNCT3_BEQ, 32'd5, 32'd5, 1'b0);
      step(OPCODE_OP_IMM, FUNCT3_BEQ, 32'd5, 32'd5, 1'b0);
      check("count3", branch_count, 32'd3);
      step(OPCODE_BRANCH, FUNCT3_BNE, 32'd7, 32'd7, 1'b0);

      for (int i = 0; i < 24; i++) begin
         word_t x;
         word_t y;
         x = $urandom;
         y = ($urandom_range(0, 3) == 0) ? x : $urandom;
         step(($urandom_range(0, 1) == 1) ?
              OPCODE_BRANCH : OPCODE_OP_IMM,
              funct3_t'($urandom_range(0, 7)),
              x, y, 1'b0);
      end

      // asynchronous clear in the middle of a cycle
      step(OPCODE_BRANCH, FUNCT3_BEQ, 32'd1, 32'd1, 1'b0);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_taken_q", 32'(taken_q), 32'd0);
      check("async_count", branch_count, 32'd0);
      mdl_cnt = '0;
      step(OPCODE_BRANCH, FUNCT3_BLTU, 32'd1, 32'd2, 1'b1);

      // counter rollover
      @(negedge clk);
      instr.opcode = OPCODE_OP_IMM;
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      #1;
      check("preload", branch_count, 32'hFFFF_FFFF);
      mdl_cnt = 32'hFFFF_FFFF;
      step(OPCODE_BRANCH, FUNCT3_BGE, 32'd3, 32'd3, 1'b0);
      check("wrap", branch_count, 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
